alu_muldiv_seq: RTL and testbench

- Multi-cycle sequencer that drives the shared 8-bit combinational ALU, one ALU operation per clock, to perform unsigned 8x8 multiply (low 8 bits) and unsigned 8/8 divide.
- Multiply is shift-and-add; divide is repeated subtraction.
- Sits between the control unit (start/done handshake) and the ALU operand/opcode inputs.
- The ALU is external; this block only sequences it.

---
 rtl/alu_muldiv_seq.sv | 100 ++++++++++
 tb/tb_alu_muldiv_seq.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: drives a shared 8-bit ALU one op per clock for unsigned mul/div (MUL_SKIP_ZERO_EN skips zero-bit adds)
module alu_muldiv_seq #(
  parameter logic [2:0] OP_ADD = 3'b000,
  parameter logic [2:0] OP_SUB = 3'b100,
  parameter logic [2:0] OP_SFT = 3'b011,
  parameter logic [2:0] OP_LT  = 3'b110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cmd,
  input  logic [7:0] opa,
  input  logic [7:0] opb,
  output logic       busy,
  output logic       done,
  output logic [7:0] res,
  output logic [7:0] rmd,
  output logic       dz,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_r
);
  typedef enum logic [2:0] {IDLE, M_SFT, M_ADD, D_CMP, D_SUB, D_INC, DONE} state_t;
  state_t state, state_nx;
  logic [7:0] a, b, tmp;
  logic [2:0] i;
  logic accept;
  assign accept = start && (state == IDLE || state == DONE);
  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
  // ALU operand/opcode drive, idle ops are all-zero
  always_comb begin
    alu_a = 8'h00;
    alu_b = 8'h00;
    alu_op = 3'b000;
    case (state)
      M_SFT: begin alu_a = a; alu_b = {5'b0, i}; alu_op = OP_SFT; end
      M_ADD: begin alu_a = res; alu_b = b[i] ? tmp : 8'h00; alu_op = OP_ADD; end
      D_CMP: begin alu_a = rmd; alu_b = b; alu_op = OP_LT; end
      D_SUB: begin alu_a = rmd; alu_b = b; alu_op = OP_SUB; end
      D_INC: begin alu_a = res; alu_b = 8'h01; alu_op = OP_ADD; end
      default: ;
    endcase
  end
  // next-state sequencing
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = accept ? (cmd ? (opb == 8'h00 ? DONE : D_CMP) : M_SFT) : IDLE;
`ifdef MUL_SKIP_ZERO_EN
      M_SFT: state_nx = b[i] ? M_ADD : (i == 3'd7 ? DONE : M_SFT);
`else
      M_SFT: state_nx = M_ADD;
`endif
      M_ADD: state_nx = i == 3'd7 ? DONE : M_SFT;
      D_CMP: state_nx = alu_r[0] ? DONE : D_SUB;
      D_SUB: state_nx = D_INC;
      D_INC: state_nx = D_CMP;
      default: state_nx = IDLE;
    endcase
  end
  // state, operand latches and ALU result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a <= 8'h00;
      b <= 8'h00;
      tmp <= 8'h00;
      i <= 3'd0;
      res <= 8'h00;
      rmd <= 8'h00;
      dz <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a <= opa;
        b <= opb;
        tmp <= 8'h00;
        i <= 3'd0;
        dz <= cmd && opb == 8'h00;
        res <= (cmd && opb == 8'h00) ? 8'hFF : 8'h00;
        rmd <= cmd ? opa : 8'h00;
      end else begin
        case (state)
          M_SFT: begin
            tmp <= alu_r;
`ifdef MUL_SKIP_ZERO_EN
            if (!b[i]) i <= i + 3'd1;
`endif
          end
          M_ADD: begin res <= alu_r; i <= i + 3'd1; end
          D_SUB: rmd <= alu_r;
          D_INC: res <= alu_r;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: table-driven, hand-written and random checks of alu_muldiv_seq against an arithmetic model
module tb_alu_muldiv_seq;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cmd = 1'b0;
  logic [7:0] opa = 8'h00, opb = 8'h00;
  logic busy, done, dz;
  logic [7:0] res, rmd, alu_a, alu_b, alu_r;
  logic [2:0] alu_op;
  int checks = 0, errors = 0;
  typedef struct {logic c; logic [7:0] a, b, er, em; logic ed;} vec_t;
  vec_t tbl[8];
  always #5 clk = ~clk;
  alu_muldiv_seq dut (.clk(clk), .rst(rst), .start(start), .cmd(cmd), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .res(res), .rmd(rmd), .dz(dz),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_r(alu_r));
  // external ALU
  always_comb begin
    alu_r = 8'h00;
    case (alu_op)
      3'b000: alu_r = alu_a + alu_b;
      3'b100: alu_r = alu_a - alu_b;
      3'b011: alu_r = alu_b[7] ? alu_a >> alu_b[2:0] : alu_a << alu_b[2:0];
      3'b110: alu_r = {7'b0, alu_a < alu_b};
      default: alu_r = 8'h00;
    endcase
  end
  function automatic int mlat(input logic [7:0] y);
`ifdef MUL_SKIP_ZERO_EN
    return 8 + $countones(y);
`else
    return 16;
`endif
  endfunction
  function automatic int lat_of(input logic c, input logic [7:0] x, input logic [7:0] y);
    return c ? (y == 0 ? 0 : 3 * (x / y) + 1) : mlat(y);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic wait_done(input logic c, input logic dz0, output int cyc, output int nb, output logic op_ok);
    logic [2:0] eop;
    cyc = 1;
    nb = 0;
    op_ok = 1'b1;
    while (!done && cyc <= 1000) begin
      if (busy) nb++;
      eop = c ? ((cyc - 1) % 3 == 0 ? 3'b110 : (cyc - 1) % 3 == 1 ? 3'b100 : 3'b000)
              : (cyc % 2 == 1 ? 3'b011 : 3'b000);
`ifdef MUL_SKIP_ZERO_EN
      if (c && !dz0 && alu_op !== eop) op_ok = 1'b0;
`else
      if (!dz0 && alu_op !== eop) op_ok = 1'b0;
`endif
      @(negedge clk);
      cyc++;
    end
  endtask
  task automatic do_cmd(input string nm, input logic c, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] er, input logic [7:0] em, input logic ed);
    int cyc, nb, lat;
    logic op_ok;
    lat = lat_of(c, x, y);
    @(negedge clk);
    start = 1'b1; cmd = c; opa = x; opb = y;
    @(negedge clk);
    start = 1'b0;
    wait_done(c, c && y == 0, cyc, nb, op_ok);
    chk({nm, "_lat"}, cyc, lat + 1);
    chk({nm, "_busy"}, nb, lat);
    chk({nm, "_ops"}, op_ok, 1);
    chk({nm, "_res"}, res, er);
    chk({nm, "_rmd"}, rmd, em);
    chk({nm, "_dz"}, dz, ed);
    @(negedge clk);
    chk({nm, "_pulse"}, {busy, done}, 0);
    chk({nm, "_hold"}, {res, rmd, 7'b0, dz}, {er, em, 7'b0, ed});
  endtask
  initial begin
    int cyc, nb;
    logic op_ok, c;
    logic [7:0] x, y;
    tbl[0] = '{1'b0, 8'd13, 8'd11, 8'h8F, 8'h00, 1'b0};
    tbl[1] = '{1'b0, 8'h20, 8'h10, 8'h00, 8'h00, 1'b0};
    tbl[2] = '{1'b1, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0};
    tbl[3] = '{1'b1, 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1};
    tbl[4] = '{1'b0, 8'd13, 8'h81, 8'h8D, 8'h00, 1'b0};
    tbl[5] = '{1'b1, 8'd7, 8'd9, 8'd0, 8'd7, 1'b0};
    tbl[6] = '{1'b0, 8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0};
    tbl[7] = '{1'b1, 8'd255, 8'd1, 8'd255, 8'd0, 1'b0};
    repeat (2) @(negedge clk);
    chk("rst_ctl", {busy, done, dz}, 0);
    chk("rst_res", {res, rmd}, 0);
    chk("rst_alu", {alu_a, alu_b, 5'b0, alu_op}, 0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++)
      do_cmd($sformatf("vec%0d", k), tbl[k].c, tbl[k].a, tbl[k].b, tbl[k].er, tbl[k].em, tbl[k].ed);
    @(negedge clk);
    start = 1'b1; cmd = 1'b1; opa = 8'd100; opb = 8'd7;
    @(negedge clk);
    cmd = 1'b0; opa = 8'd3; opb = 8'd5;
    wait_done(1'b1, 1'b0, cyc, nb, op_ok);
    chk("hold_lat", cyc, 44);
    chk("hold_ops", op_ok, 1);
    chk("hold_res", {res, rmd}, {8'd14, 8'd2});
    @(negedge clk);
    start = 1'b0;
    chk("hold_acc", busy, 1);
    wait_done(1'b0, 1'b0, cyc, nb, op_ok);
    chk("hold_mul_lat", cyc, mlat(8'd5) + 1);
    chk("hold_mul_res", {res, rmd, 7'b0, dz}, {8'd15, 8'd0, 8'd0});
    @(negedge clk);
    start = 1'b1; cmd = 1'b1; opa = 8'd200; opb = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", {busy, done}, 0);
    chk("mid_rst_res", {res, rmd, 7'b0, dz}, 0);
    chk("mid_rst_alu", {alu_a, alu_b, 5'b0, alu_op}, 0);
    rst = 1'b0;
    nb = 0;
    repeat (250) begin
      @(negedge clk);
      if (done || busy) nb++;
    end
    chk("mid_rst_quiet", nb, 0);
    for (int k = 0; k < 40; k++) begin
      c = 1'($urandom_range(0, 1));
      x = 8'($urandom);
      y = $urandom_range(0, 4) == 0 ? 8'($urandom_range(0, 2)) : 8'($urandom);
      do_cmd($sformatf("rnd%0d", k), c, x, y,
             c ? (y == 0 ? 8'hFF : x / y) : 8'((16'(x) * 16'(y)) & 16'hFF),
             c ? (y == 0 ? x : x % y) : 8'h00, c && y == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
